gnn_sched: RTL and testbench



---
 rtl/gnn_pkg.sv | 28 ++
 rtl/gnn_aggr.sv | 24 ++
 rtl/gnn_sched.sv | 174 +++++++++++++++++
 tb/tb_gnn_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gnn_pkg.sv
// Shared constants, adjacency masks and FSM state type for the GNN node sequencer.
package gnn_pkg;

   localparam int N_NODES = 4;
   localparam int N_FEAT  = 4;
   localparam int X_W     = 5;
   localparam int XA_W    = 7;
   localparam int Y_W     = 15;
   localparam int YA_W    = 17;
   localparam int OUT_W   = 21;

   localparam int FEAT_W = N_NODES * N_FEAT * X_W;
   localparam int YVEC_W = N_FEAT * Y_W;
   localparam int OPND_W = N_FEAT * YA_W;
   localparam int RSPO_W = 2 * OUT_W;
   localparam int OUTV_W = N_NODES * RSPO_W;

   // Diamond graph with self-loops: bit m set means node m feeds the aggregate.
   localparam logic [N_NODES-1:0] ADJ_MASK [N_NODES] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FIN
   } state_t;

endpackage

// File: rtl/gnn_aggr.sv
// Masked sum of four signed lanes; the adjacency mask selects three of them.
module gnn_aggr
   import gnn_pkg::*;
#(
   parameter int IN_W  = 15,
   parameter int OUT_W = 17
) (
   input  logic [N_NODES*IN_W-1:0] vals,
   input  logic [N_NODES-1:0]      mask,
   output logic signed [OUT_W-1:0] sum
);

   logic [IN_W-1:0] v;

   always_comb begin
      sum = '0;
      v   = '0;
      for (int i = 0; i < N_NODES; i++) begin
         v = vals[i*IN_W +: IN_W];
         if (mask[i]) sum = sum + {{(OUT_W-IN_W){v[IN_W-1]}}, v};
      end
   end

endmodule

// File: rtl/gnn_sched.sv
// Time-shares one layer-1/layer-2 node engine across the four graph nodes.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_IDLE  | waiting for start; results (if any) held with out_valid
//  S_ISSUE | eng_req high with layer/node/operands, waiting for eng_ack
//  S_WAIT  | job accepted, waiting for eng_rsp_valid or timeout
//  S_FIN   | all eight jobs returned; pulse done, raise out_valid
module gnn_sched
   import gnn_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [FEAT_W-1:0] feat_in,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [OUTV_W-1:0] out_vec,
   output logic              out_valid,
   output logic              eng_req,
   output logic              eng_layer,
   output logic [1:0]        eng_node,
   output logic [OPND_W-1:0] eng_opnd,
   input  logic              eng_ack,
   input  logic              eng_rsp_valid,
   input  logic [YVEC_W-1:0] eng_rsp_y,
   input  logic [RSPO_W-1:0] eng_rsp_out
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t                          state;
   logic [1:0]                      node;
   logic                            layer;
   logic [7:0]                      timer;
   logic [FEAT_W-1:0]               feat;
   logic [N_NODES*YVEC_W-1:0]       ybuf;

   logic [1:0]                      src_node;
   logic                            src_layer;
   logic [FEAT_W-1:0]               src_feat;
   logic [N_NODES*YVEC_W-1:0]       src_ybuf;
   logic [X_W-1:0]                  xv;
   logic [N_NODES*Y_W-1:0]          lane_in  [N_FEAT];
   logic [YA_W-1:0]                 lane_sum [N_FEAT];
   logic [OPND_W-1:0]               opnd_next;

   // Operands are built for the job about to be issued, so the sources are the
   // values being written this cycle (new features, or the y just returned).
   always_comb begin
      src_node  = node + 2'd1;
      src_layer = layer;
      src_feat  = feat;
      src_ybuf  = ybuf;
      if (state == S_IDLE) begin
         src_node  = '0;
         src_layer = 1'b0;
         src_feat  = feat_in;
      end else begin
         if (node == 2'd3) src_layer = 1'b1;
         if (!layer) src_ybuf[int'(node)*YVEC_W +: YVEC_W] = eng_rsp_y;
      end
   end

   always_comb begin
      xv = '0;
      for (int f = 0; f < N_FEAT; f++) begin
         lane_in[f] = '0;
         for (int m = 0; m < N_NODES; m++) begin
            xv = src_feat[(m*N_FEAT+f)*X_W +: X_W];
            if (src_layer)
               lane_in[f][m*Y_W +: Y_W] = src_ybuf[m*YVEC_W + f*Y_W +: Y_W];
            else
               lane_in[f][m*Y_W +: Y_W] = {{(Y_W-X_W){xv[X_W-1]}}, xv};
         end
      end
   end

   for (genvar f = 0; f < N_FEAT; f++) begin : g_lane
      gnn_aggr #(.IN_W(Y_W), .OUT_W(YA_W)) u_aggr (
         .vals (lane_in[f]),
         .mask (ADJ_MASK[src_node]),
         .sum  (lane_sum[f])
      );
   end

   always_comb begin
      opnd_next = '0;
      for (int f = 0; f < N_FEAT; f++) opnd_next[f*YA_W +: YA_W] = lane_sum[f];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         node      <= '0;
         layer     <= 1'b0;
         timer     <= '0;
         feat      <= '0;
         ybuf      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         out_vec   <= '0;
         out_valid <= 1'b0;
         eng_req   <= 1'b0;
         eng_layer <= 1'b0;
         eng_node  <= '0;
         eng_opnd  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  feat      <= feat_in;
                  err       <= 1'b0;
                  out_valid <= 1'b0;
                  out_vec   <= '0;
                  busy      <= 1'b1;
                  node      <= '0;
                  layer     <= 1'b0;
                  eng_req   <= 1'b1;
                  eng_node  <= '0;
                  eng_layer <= 1'b0;
                  eng_opnd  <= opnd_next;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (eng_ack) begin
                  eng_req <= 1'b0;
                  timer   <= '0;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (eng_rsp_valid) begin
                  if (!layer) ybuf[int'(node)*YVEC_W +: YVEC_W] <= eng_rsp_y;
                  else out_vec[int'(node)*RSPO_W +: RSPO_W] <= eng_rsp_out;
                  if (layer && node == 2'd3) begin
                     state <= S_FIN;
                  end else begin
                     node      <= src_node;
                     layer     <= src_layer;
                     eng_req   <= 1'b1;
                     eng_node  <= src_node;
                     eng_layer <= src_layer;
                     eng_opnd  <= opnd_next;
                     state     <= S_ISSUE;
                  end
               end else if (timer == TMO_LAST) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            S_FIN: begin
               done      <= 1'b1;
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         // A response with no job outstanding is a protocol error; the FSM ignores it.
         if (eng_rsp_valid && state != S_WAIT) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gnn_sched.sv
// Directed bench for gnn_sched with a ReLU engine model (all weights = 1).
module tb_gnn_sched;
   import gnn_pkg::*;

   logic              clk, rst, start;
   logic [FEAT_W-1:0] feat_in;
   logic              busy, done, err, out_valid;
   logic [OUTV_W-1:0] out_vec;
   logic              eng_req, eng_layer;
   logic [1:0]        eng_node;
   logic [OPND_W-1:0] eng_opnd;
   logic              eng_ack, rsp_v, stray;
   logic [YVEC_W-1:0] rsp_y;
   logic [RSPO_W-1:0] rsp_out;

   gnn_sched #(.TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .start(start), .feat_in(feat_in),
      .busy(busy), .done(done), .err(err), .out_vec(out_vec), .out_valid(out_valid),
      .eng_req(eng_req), .eng_layer(eng_layer), .eng_node(eng_node), .eng_opnd(eng_opnd),
      .eng_ack(eng_ack), .eng_rsp_valid(rsp_v | stray), .eng_rsp_y(rsp_y),
      .eng_rsp_out(rsp_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [FEAT_W-1:0]             feat;
      logic [N_NODES-1:0][OPND_W-1:0] l1;
      logic [N_NODES-1:0][OPND_W-1:0] l2;
      logic [OUTV_W-1:0]             outv;
   } vec_t;

   vec_t tv [5];
   int   n_vec = 0;
   int   n_mis = 0;
   int   ack_dly = 0;
   int   rsp_lat = 2;
   bit   rsp_en = 1'b1;
   int   job_cnt = 0;
   int   done_cnt = 0;
   logic              jl_layer [128];
   logic [1:0]        jl_node  [128];
   logic [OPND_W-1:0] jl_opnd  [128];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [FEAT_W-1:0] mk_feat(input int v0, v1, v2, v3, input bit lo);
      int v [4];
      logic [FEAT_W-1:0] r;
      v = '{v0, v1, v2, v3};
      r = '0;
      for (int n = 0; n < 4; n++)
         for (int f = 0; f < 4; f++) r[(n*4+f)*5 +: 5] = 5'(v[n] + (lo ? f : 0));
      return r;
   endfunction

   function automatic logic [N_NODES-1:0][OPND_W-1:0] mk_op(input int a0, a1, a2, a3, input bit lo);
      int a [4];
      logic [N_NODES-1:0][OPND_W-1:0] r;
      a = '{a0, a1, a2, a3};
      r = '0;
      for (int n = 0; n < 4; n++)
         for (int f = 0; f < 4; f++) r[n][f*17 +: 17] = 17'(a[n] + (lo ? 3*f : 0));
      return r;
   endfunction

   function automatic logic [OUTV_W-1:0] mk_out(input int o0, o1, o2, o3);
      int o [4];
      logic [OUTV_W-1:0] r;
      o = '{o0, o1, o2, o3};
      r = '0;
      for (int n = 0; n < 4; n++)
         for (int k = 0; k < 2; k++) r[(n*2+k)*21 +: 21] = 21'(o[n]);
      return r;
   endfunction

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // Engine model: optional ack delay, response rsp_lat cycles after handshake.
   initial begin : engine
      logic [70:0]       snap;
      logic              lay;
      logic [OPND_W-1:0] op;
      logic signed [16:0] t;
      int s;
      eng_ack = 1'b0; rsp_v = 1'b0; rsp_y = '0; rsp_out = '0;
      forever begin
         if (eng_req === 1'b1 && rst === 1'b0) begin
            snap = {eng_layer, eng_node, eng_opnd};
            for (int k = 0; k < ack_dly; k++) begin
               @(posedge clk); #1;
               chk("req_stable", {eng_req, eng_layer, eng_node, eng_opnd}, {1'b1, snap});
            end
            if (job_cnt < 128) begin
               jl_layer[job_cnt] = eng_layer;
               jl_node[job_cnt]  = eng_node;
               jl_opnd[job_cnt]  = eng_opnd;
            end
            job_cnt++;
            lay = eng_layer;
            op  = eng_opnd;
            eng_ack = 1'b1;
            @(posedge clk); #1;
            eng_ack = 1'b0;
            if (rsp_en) begin
               repeat (rsp_lat - 1) @(posedge clk);
               #1;
               s = 0;
               for (int f = 0; f < 4; f++) begin
                  t = op[f*17 +: 17];
                  s += int'(t);
               end
               if (!lay) begin
                  if (s < 0) s = 0;
                  for (int i = 0; i < 4; i++) rsp_y[i*15 +: 15] = 15'(s);
               end else begin
                  rsp_out = {21'(s), 21'(s)};
               end
               rsp_v = 1'b1;
               @(posedge clk); #1;
               rsp_v = 1'b0;
            end
         end else begin
            @(posedge clk); #1;
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
   endtask

   task automatic run_vec(input int idx, input int lat_exp, input bit glitch);
      int jb, db, lat, ix;
      jb = job_cnt;
      db = done_cnt;
      feat_in = tv[idx].feat;
      pulse_start();
      chk("start_busy", busy, 1'b1);
      chk("start_err_clr", err, 1'b0);
      chk("start_clr", {out_valid, out_vec}, '0);
      lat = 0;
      for (int c = 1; c <= 1500; c++) begin
         if (glitch && c == 10) begin
            feat_in = tv[3].feat;
            start = 1'b1;
         end
         if (glitch && c == 11) start = 1'b0;
         @(posedge clk); #1;
         if (done) begin
            lat = c;
            break;
         end
      end
      chk("done_latency", lat, lat_exp);
      chk("out_vec", out_vec, tv[idx].outv);
      chk("fin_flags", {out_valid, busy, err}, 3'b100);
      @(posedge clk); #1;
      chk("done_single", {done, 32'(done_cnt - db)}, {1'b0, 32'd1});
      chk("job_count", job_cnt - jb, 8);
      for (int j = 0; j < 8; j++) begin
         ix = (jb + j) % 128;
         chk("job_order", {jl_layer[ix], jl_node[ix]}, {j >= 4, 2'(j % 4)});
         chk("job_opnd", jl_opnd[ix], (j < 4) ? tv[idx].l1[j%4] : tv[idx].l2[j%4]);
      end
   endtask

   initial begin
      int lat, db;
      bit hit;
      tv[0] = '{feat: mk_feat(1, 1, 1, 1, 0), l1: mk_op(3, 3, 3, 3, 0),
                l2: mk_op(36, 36, 36, 36, 0), outv: mk_out(144, 144, 144, 144)};
      tv[1] = '{feat: mk_feat(-16, -16, -16, -16, 0), l1: mk_op(-48, -48, -48, -48, 0),
                l2: mk_op(0, 0, 0, 0, 0), outv: mk_out(0, 0, 0, 0)};
      tv[2] = '{feat: mk_feat(1, 2, 3, 4, 0), l1: mk_op(6, 7, 8, 9, 0),
                l2: mk_op(84, 88, 92, 96, 0), outv: mk_out(336, 352, 368, 384)};
      tv[3] = '{feat: mk_feat(5, -7, 2, 0, 1), l1: mk_op(0, -2, 7, -5, 1),
                l2: mk_op(74, 28, 64, 56, 0), outv: mk_out(296, 112, 256, 224)};
      tv[4] = '{feat: mk_feat(15, 15, 15, 15, 0), l1: mk_op(45, 45, 45, 45, 0),
                l2: mk_op(540, 540, 540, 540, 0), outv: mk_out(2160, 2160, 2160, 2160)};

      rst = 1'b1; start = 1'b0; stray = 1'b0; feat_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {busy, done, err, out_valid, eng_req, eng_layer, eng_node, eng_opnd, out_vec}, '0);
      chk("reset_state", dut.state, S_IDLE);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(i, 25, 1'b0);

      ack_dly = 3; rsp_lat = 1;
      run_vec(2, 41, 1'b0);
      ack_dly = 0; rsp_lat = 2;

      // Engine never responds: abort after 255 WAIT cycles.
      rsp_en = 1'b0;
      db = done_cnt;
      feat_in = tv[0].feat;
      pulse_start();
      lat = 0;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk); #1;
         if (!busy) begin
            lat = c;
            break;
         end
      end
      chk("timeout_cycles", lat, 256);
      chk("timeout_flags", {err, out_valid, eng_req}, 3'b100);
      chk("timeout_no_done", done_cnt - db, 0);
      rsp_en = 1'b1;
      run_vec(0, 25, 1'b0);

      // Reset during layer-2 node-1 WAIT.
      feat_in = tv[2].feat;
      pulse_start();
      hit = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (eng_req && eng_ack && eng_layer && eng_node == 2'd1) begin
            hit = 1'b1;
            break;
         end
      end
      chk("rst_job_seen", hit, 1'b1);
      db = done_cnt;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_outs", {busy, done, err, out_valid, eng_req, eng_layer, eng_node, eng_opnd, out_vec}, '0);
      chk("midrst_state", dut.state, S_IDLE);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_after", {err, busy, 32'(done_cnt - db)}, '0);
      run_vec(3, 25, 1'b0);

      // Mid-run start ignored; stray response in IDLE flags err only.
      run_vec(2, 25, 1'b1);
      @(negedge clk); stray = 1'b1;
      @(negedge clk); stray = 1'b0;
      chk("stray_err", {err, busy, out_valid, eng_req}, 4'b1010);
      chk("stray_out_hold", out_vec, tv[2].outv);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
